// File: rtl/pipeline_stall_ctrl.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes and
// data-memory wait stalls for the 5-stage core, plus performance counters.
module pipeline_stall_ctrl #(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned MEM_TIMEOUT = 64,
   parameter int unsigned TO_W        = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       Rs1_D,
   input  logic [4:0]       Rs2_D,
   input  logic [4:0]       RD_E,
   input  logic             MemReadE,
   input  logic             PCSrcE,
   input  logic             mem_req_M,
   input  logic             mem_ready,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushW,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic [0:0] {StRun, StMemWait} state_e;

   localparam logic [TO_W-1:0]  TimeoutVal = TO_W'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] CntMax     = '1;

   state_e            state_q, state_d;
   logic [TO_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic              mem_timeout_q, mem_timeout_d;
   logic [CNT_W-1:0]  stall_count_q, stall_count_d;
   logic [CNT_W-1:0]  flush_count_q, flush_count_d;
   logic              load_use;
   logic              mem_stall;
   logic              branch_flush;

   always_comb begin
      load_use  = MemReadE && (RD_E != 5'd0) && ((RD_E == Rs1_D) || (RD_E == Rs2_D));
      mem_stall = (state_q == StRun) ? (mem_req_M && !mem_ready) : !mem_ready;

      StallF       = 1'b0;
      StallD       = 1'b0;
      StallE       = 1'b0;
      StallM       = 1'b0;
      FlushD       = 1'b0;
      FlushE       = 1'b0;
      FlushW       = 1'b0;
      branch_flush = 1'b0;

      // E is frozen during a memory wait, so branch and load-use re-present later.
      if (!rst) begin
         if (mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
         end else if (PCSrcE) begin
            FlushD       = 1'b1;
            FlushE       = 1'b1;
            branch_flush = 1'b1;
         end else if (load_use) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StRun:     if (mem_req_M && !mem_ready) state_d = StMemWait;
         StMemWait: if (mem_ready) state_d = StRun;
         default:   state_d = StRun;
      endcase

      // mem_stall is true exactly when the next state is MEM_WAIT.
      wait_cnt_d = '0;
      if (mem_stall) begin
         wait_cnt_d = (wait_cnt_q == TimeoutVal) ? wait_cnt_q : wait_cnt_q + 1'b1;
      end
      mem_timeout_d = mem_timeout_q || (mem_stall && (wait_cnt_d == TimeoutVal));

      stall_count_d = stall_count_q;
      if (StallF && (stall_count_q != CntMax)) begin
         stall_count_d = stall_count_q + 1'b1;
      end
      flush_count_d = flush_count_q;
      if (branch_flush && (flush_count_q != CntMax)) begin
         flush_count_d = flush_count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StRun;
         wait_cnt_q    <= '0;
         mem_timeout_q <= 1'b0;
         stall_count_q <= '0;
         flush_count_q <= '0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         mem_timeout_q <= mem_timeout_d;
         stall_count_q <= stall_count_d;
         flush_count_q <= flush_count_d;
      end
   end

   assign mem_timeout = mem_timeout_q;
   assign stall_count = stall_count_q;
   assign flush_count = flush_count_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl, built with CNT_W=4 and MEM_TIMEOUT=4
// so counter saturation and the timeout are reachable in a short run.
module tb_pipeline_stall_ctrl;

   localparam int unsigned CntW = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [4:0]      Rs1_D = '0, Rs2_D = '0, RD_E = '0;
   logic            MemReadE = 1'b0, PCSrcE = 1'b0, mem_req_M = 1'b0, mem_ready = 1'b0;
   logic            StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
   logic            mem_timeout;
   logic [CntW-1:0] stall_count, flush_count;
   logic [6:0]      ctl;

   int n_checks = 0;
   int n_fail   = 0;

   // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
   localparam logic [6:0] CtlNone   = 7'b0000000;
   localparam logic [6:0] CtlLoad   = 7'b1100010;
   localparam logic [6:0] CtlBranch = 7'b0000110;
   localparam logic [6:0] CtlMem    = 7'b1111001;

   assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

   always #5 clk = ~clk;

   pipeline_stall_ctrl #(
      .CNT_W       (CntW),
      .MEM_TIMEOUT (4),
      .TO_W        (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .Rs1_D       (Rs1_D),
      .Rs2_D       (Rs2_D),
      .RD_E        (RD_E),
      .MemReadE    (MemReadE),
      .PCSrcE      (PCSrcE),
      .mem_req_M   (mem_req_M),
      .mem_ready   (mem_ready),
      .StallF      (StallF),
      .StallD      (StallD),
      .StallE      (StallE),
      .StallM      (StallM),
      .FlushD      (FlushD),
      .FlushE      (FlushE),
      .FlushW      (FlushW),
      .mem_timeout (mem_timeout),
      .stall_count (stall_count),
      .flush_count (flush_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      Rs1_D = '0; Rs2_D = '0; RD_E = '0;
      MemReadE = 1'b0; PCSrcE = 1'b0; mem_req_M = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      PCSrcE = 1'b1; MemReadE = 1'b1; RD_E = 5'd3; Rs1_D = 5'd3; mem_req_M = 1'b1;
      #1;
      n_checks++;
      if (ctl !== CtlNone) begin
         n_fail++; $display("FAIL reset_ctl got %b want %b", ctl, CtlNone);
      end
      tick();
      idle();
      rst = 1'b0;
      #1;
      n_checks++;
      if (stall_count !== 4'd0 || flush_count !== 4'd0 || mem_timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state got sc=%0d fc=%0d to=%b want 0 0 0",
                  stall_count, flush_count, mem_timeout);
      end
      n_checks++;
      if (ctl !== CtlNone) begin
         n_fail++; $display("FAIL reset_idle_ctl got %b want %b", ctl, CtlNone);
      end
   endtask

   task automatic test_load_use();
      do_reset();
      MemReadE = 1'b1; RD_E = 5'd5; Rs1_D = 5'd5; Rs2_D = 5'd9;
      #1;
      n_checks++;
      if (ctl !== CtlLoad) begin
         n_fail++; $display("FAIL load_use_rs1 got %b want %b", ctl, CtlLoad);
      end
      tick();
      MemReadE = 1'b0; RD_E = 5'd0;  // bubble now in E
      #1;
      n_checks++;
      if (ctl !== CtlNone || stall_count !== 4'd1) begin
         n_fail++;
         $display("FAIL load_use_bubble got ctl=%b sc=%0d want %b 1", ctl, stall_count, CtlNone);
      end
      tick();
      MemReadE = 1'b1; RD_E = 5'd0; Rs1_D = 5'd0; Rs2_D = 5'd0;
      #1;
      n_checks++;
      if (ctl !== CtlNone) begin
         n_fail++; $display("FAIL load_use_x0 got %b want %b", ctl, CtlNone);
      end
      tick();
      RD_E = 5'd7; Rs1_D = 5'd1; Rs2_D = 5'd7;
      #1;
      n_checks++;
      if (ctl !== CtlLoad) begin
         n_fail++; $display("FAIL load_use_rs2 got %b want %b", ctl, CtlLoad);
      end
      tick();
      idle();
      #1;
      n_checks++;
      if (stall_count !== 4'd2) begin
         n_fail++; $display("FAIL load_use_count got %0d want 2", stall_count);
      end
   endtask

   task automatic test_branch_vs_load_use();
      do_reset();
      PCSrcE = 1'b1; MemReadE = 1'b1; RD_E = 5'd5; Rs1_D = 5'd5;
      #1;
      n_checks++;
      if (ctl !== CtlBranch) begin
         n_fail++; $display("FAIL branch_prio got %b want %b", ctl, CtlBranch);
      end
      tick();
      idle();
      #1;
      n_checks++;
      if (flush_count !== 4'd1 || stall_count !== 4'd0) begin
         n_fail++;
         $display("FAIL branch_counts got fc=%0d sc=%0d want 1 0", flush_count, stall_count);
      end
   endtask

   task automatic test_mem_wait();
      do_reset();
      mem_req_M = 1'b1; mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         PCSrcE = (i == 1);  // must be masked by the memory stall
         MemReadE = (i == 2); RD_E = 5'd4; Rs1_D = 5'd4;
         #1;
         n_checks++;
         if (ctl !== CtlMem) begin
            n_fail++; $display("FAIL mem_wait_cycle%0d got %b want %b", i, ctl, CtlMem);
         end
         tick();
      end
      idle();
      mem_req_M = 1'b1; mem_ready = 1'b1;
      #1;
      n_checks++;
      if (ctl !== CtlNone) begin
         n_fail++; $display("FAIL mem_ready_cycle got %b want %b", ctl, CtlNone);
      end
      tick();
      n_checks++;
      if (stall_count !== 4'd3 || flush_count !== 4'd0 || mem_timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL mem_wait_counts got sc=%0d fc=%0d to=%b want 3 0 0",
                  stall_count, flush_count, mem_timeout);
      end
      // Ready on the first request cycle: no stall.
      #1;
      n_checks++;
      if (ctl !== CtlNone) begin
         n_fail++; $display("FAIL mem_ready_first got %b want %b", ctl, CtlNone);
      end
      tick();
      // Back in RUN: ready low without a request must not stall.
      mem_req_M = 1'b0; mem_ready = 1'b0;
      #1;
      n_checks++;
      if (ctl !== CtlNone || stall_count !== 4'd3) begin
         n_fail++;
         $display("FAIL mem_back_to_run got ctl=%b sc=%0d want %b 3", ctl, stall_count, CtlNone);
      end
      tick();
   endtask

   task automatic test_timeout();
      do_reset();
      mem_req_M = 1'b1; mem_ready = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         n_checks++;
         if (mem_timeout !== (i >= 4)) begin
            n_fail++;
            $display("FAIL timeout_wait%0d got %b want %b", i, mem_timeout, (i >= 4));
         end
      end
      mem_ready = 1'b1;
      #1;
      n_checks++;
      if (ctl !== CtlNone) begin
         n_fail++; $display("FAIL timeout_release got %b want %b", ctl, CtlNone);
      end
      tick();
      idle();
      tick();
      n_checks++;
      if (mem_timeout !== 1'b1 || stall_count !== 4'd10) begin
         n_fail++;
         $display("FAIL timeout_sticky got to=%b sc=%0d want 1 10", mem_timeout, stall_count);
      end
      do_reset();
      n_checks++;
      if (mem_timeout !== 1'b0) begin
         n_fail++; $display("FAIL timeout_clear got %b want 0", mem_timeout);
      end
   endtask

   task automatic test_reset_mid_wait();
      do_reset();
      mem_req_M = 1'b1; mem_ready = 1'b0;
      tick();
      tick();
      n_checks++;
      if (stall_count !== 4'd2) begin
         n_fail++; $display("FAIL midwait_pre got %0d want 2", stall_count);
      end
      rst = 1'b1; PCSrcE = 1'b1;
      #1;
      n_checks++;
      if (ctl !== CtlNone) begin
         n_fail++; $display("FAIL midwait_rst_ctl got %b want %b", ctl, CtlNone);
      end
      tick();
      rst = 1'b0; idle();
      #1;
      n_checks++;
      if (ctl !== CtlNone || stall_count !== 4'd0 || flush_count !== 4'd0 ||
          mem_timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL midwait_after got ctl=%b sc=%0d fc=%0d to=%b want %b 0 0 0",
                  ctl, stall_count, flush_count, mem_timeout, CtlNone);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 1; i <= 20; i++) begin
         MemReadE = 1'b1; RD_E = 5'd12; Rs2_D = 5'd12;
         tick();
         MemReadE = 1'b0; RD_E = 5'd0;
         tick();
         if (i == 15) begin
            n_checks++;
            if (stall_count !== 4'd15) begin
               n_fail++; $display("FAIL sat_reach got %0d want 15", stall_count);
            end
         end
      end
      n_checks++;
      if (stall_count !== 4'd15) begin
         n_fail++; $display("FAIL sat_stall_hold got %0d want 15", stall_count);
      end
      idle();
      for (int i = 1; i <= 17; i++) begin
         PCSrcE = 1'b1;
         tick();
      end
      PCSrcE = 1'b0;
      n_checks++;
      if (flush_count !== 4'd15) begin
         n_fail++; $display("FAIL sat_flush_hold got %0d want 15", flush_count);
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch_vs_load_use();
      test_mem_wait();
      test_timeout();
      test_reset_mid_wait();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
Pipeline sequencing controller for the 5-stage core; companion to the forwarding logic in the execute stage.
- Resolves the hazards forwarding cannot cover: load-use stalls, taken-branch/jump flushes and multi-cycle data-memory waits.
- Drives the stall/flush controls of the F/D, D/E, E/M and M/W pipeline registers.
- Keeps saturating performance counters and a sticky memory-timeout flag.

Parameters:
- CNT_W, 16, width of the stall_count and flush_count performance counters.
- MEM_TIMEOUT, 64, number of consecutive MEM_WAIT cycles after which mem_timeout is set (must be ≥1).
- TO_W, 8, width of the internal wait counter (must hold MEM_TIMEOUT).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- Rs1_D  in  5  decode-stage source register 1.
- Rs2_D  in  5  decode-stage source register 2.
- RD_E  in  5  execute-stage destination register.
- MemReadE  in  1  instruction in E is a load.
- PCSrcE  in  1  taken branch/jump resolved in E.
- mem_req_M  in  1  instruction in M is accessing data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- StallF  out  1  hold PC.
- StallD  out  1  hold F/D register.
- StallE  out  1  hold D/E register.
- StallM  out  1  hold E/M register.
- FlushD  out  1  clear F/D register (bubble).
- FlushE  out  1  clear D/E register (bubble).
- FlushW  out  1  clear M/W register (bubble).
- mem_timeout  out  1  sticky: memory wait exceeded MEM_TIMEOUT.
- stall_count  out  CNT_W  cycles with StallF asserted, saturating.
- flush_count  out  CNT_W  taken-branch flush events, saturating.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- While rst=1:
  - All stall/flush outputs are 0.
  - On the clock edge: state←RUN, wait_cnt←0, mem_timeout←0, stall_count←0, flush_count←0.
  - This applies mid-wait as well: any MEM_WAIT is abandoned.
- States: RUN, MEM_WAIT.
- Stall/flush outputs are combinational (same cycle) from state and inputs. Counters, wait_cnt, mem_timeout and state are registered.
- Hazard terms:
  - load_use = MemReadE & (RD_E≠0) & (RD_E==Rs1_D | RD_E==Rs2_D).
  - mem_stall = (state==RUN & mem_req_M & ~mem_ready) | (state==MEM_WAIT & ~mem_ready).
- Output priority, highest first:
  1. mem_stall → StallF=StallD=StallE=StallM=1, FlushW=1, all other flushes 0. PCSrcE and load_use are ignored because E is frozen and re-presents them after the wait.
  2. PCSrcE → FlushD=FlushE=1, no stalls. Also wins over a simultaneous load_use (no stall issued).
  3. load_use → StallF=StallD=1, FlushE=1. Exactly one stall cycle per load-use; the bubble in E clears load_use next cycle.
  4. Otherwise all outputs 0.
- State transitions:
  - RUN→MEM_WAIT when mem_req_M & ~mem_ready.
  - MEM_WAIT→RUN in the cycle mem_ready=1. Stall outputs drop in that same cycle, so the pipeline advances on that edge.
  - mem_ready=1 on the first request cycle: no stall, no state change.
- wait_cnt:
  - Counts cycles spent in MEM_WAIT; cleared on entry to RUN.
  - Saturates at MEM_TIMEOUT. When it reaches MEM_TIMEOUT, mem_timeout←1, held until rst.
  - The controller stays in MEM_WAIT; no abort.
- stall_count: +1 on every edge where StallF=1 (load-use and memory-wait cycles). Saturates at 2^CNT_W−1, no wrap.
- flush_count: +1 on every edge where priority-2 flush is active. Saturates the same way.

Test Plan:
- Load-use: lw x5 in E (MemReadE=1, RD_E=5) with Rs1_D=5 → StallF=StallD=FlushE=1 for exactly 1 cycle; stall_count 0→1. Same with RD_E=0 → no stall.
- Branch vs load-use: PCSrcE=1 and load_use true in the same cycle → FlushD=FlushE=1, StallF=0; flush_count +1, stall_count unchanged.
- Memory wait: mem_req_M=1, mem_ready low for 3 cycles then high → StallF/D/E/M=FlushW=1 for 3 cycles, 0 on the ready cycle; state back to RUN; stall_count=3. mem_ready=1 on the first cycle → no stall.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 for 10 cycles → mem_timeout rises after the 4th wait cycle and stays 1 after mem_ready returns; cleared only by rst.
- Reset mid-wait: rst=1 during MEM_WAIT with PCSrcE=1 → outputs 0 during reset; next cycle state RUN, counters 0, mem_timeout 0.
- Saturation: CNT_W=4, 20 load-use events → stall_count holds at 15, no wrap.
